// File: rtl/jump_pkg.sv
// Shared definitions for the jump controller and the instruction decoder/assembler.
//   jop_t : encoding of the 3-bit jump opcode field (value 7 is reserved and acts as NONE)
//   BLK_W : default block-address width (PC width minus the 2 in-block offset bits)
package jump_pkg;

    localparam int unsigned BLK_W = 8;

    typedef enum logic [2:0] {
        JOP_NONE = 3'd0,
        JOP_JMP  = 3'd1,
        JOP_JZ   = 3'd2,
        JOP_JNZ  = 3'd3,
        JOP_JC   = 3'd4,
        JOP_CALL = 3'd5,
        JOP_RET  = 3'd6
    } jop_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: a small LIFO with a synchronous active-high reset.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties the stack)
//   push, push_data  : write push_data on top; ignored when full
//   pop              : discard the top entry; ignored when empty
//   top              : current top entry (meaningless while empty)
//   depth            : number of valid entries, 0..DEPTH
//   full, empty      : occupancy status
module ras_stack
    import jump_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = BLK_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    top_idx;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign depth   = cnt_q;
    // Wraps to DEPTH-1 when empty; the value read there is don't-care.
    assign top_idx = cnt_q[AW-1:0] - AW'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage is not reset; only entries below cnt_q are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Jump controller: decodes the jump opcode of the current instruction, holds the
// zero/carry flags and a return-address stack, and tells the PC where to jump.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   prog_ctr            : current PC; block part + 1 is the CALL return address
//   instr_vld, jop      : opcode of the current instruction (invalid -> NONE)
//   jtarget             : block address carried by the instruction
//   flag_we, zero_in,
//   carry_in            : ALU flag update, takes effect on the clock edge
//   absjump_en, target  : combinational jump request and block address to the PC
//   ras_depth           : RAS occupancy
//   ras_ovf, ras_unf    : sticky CALL-while-full / RET-while-empty indicators
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned D         = 10,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [D-1:0]                 prog_ctr,
    input  logic                         instr_vld,
    input  logic [2:0]                   jop,
    input  logic [D-3:0]                 jtarget,
    input  logic                         flag_we,
    input  logic                         zero_in,
    input  logic                         carry_in,
    output logic                         absjump_en,
    output logic [D-3:0]                 target,
    output logic [$clog2(RAS_DEPTH):0]   ras_depth,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int unsigned BW = D - 2;

    logic          zero_q, carry_q;
    logic          ovf_q, unf_q;
    logic          push, pop, ovf_set, unf_set;
    logic [BW-1:0] ret_addr;
    logic [BW-1:0] ras_top;
    logic          ras_full, ras_empty;
    logic          unused_pc;

    // Offset bits of the PC play no part: jumps and returns are block-granular.
    assign unused_pc = ^prog_ctr[1:0];
    // Return to the start of the following block; wraps at the top of memory.
    assign ret_addr  = prog_ctr[D-1:2] + BW'(1);

    always_comb begin
        absjump_en = 1'b0;
        target     = jtarget;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (instr_vld) begin
            case (jop)
                JOP_JMP: absjump_en = 1'b1;
                JOP_JZ:  absjump_en = zero_q;
                JOP_JNZ: absjump_en = !zero_q;
                JOP_JC:  absjump_en = carry_q;
                JOP_CALL: begin
                    // Jump is taken even when the return address cannot be saved.
                    absjump_en = 1'b1;
                    if (ras_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                JOP_RET: begin
                    if (ras_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        absjump_en = 1'b1;
                        target     = ras_top;
                        pop        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flags update on the edge; jumps this cycle see the previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (flag_we) begin
                zero_q  <= zero_in;
                carry_q <= carry_in;
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (BW)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top       (ras_top),
        .depth     (ras_depth),
        .full      (ras_full),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: a queue-based reference model checked every cycle, plus
// directed sequences with literal expectations.
module tb_jump_ctrl;

    localparam int unsigned D         = 10;
    localparam int unsigned RAS_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] prog_ctr = '0;
    logic       instr_vld = 1'b0;
    logic [2:0] jop = 3'd0;
    logic [7:0] jtarget = '0;
    logic       flag_we = 1'b0;
    logic       zero_in = 1'b0;
    logic       carry_in = 1'b0;
    logic       absjump_en;
    logic [7:0] target;
    logic [2:0] ras_depth;
    logic       ras_ovf, ras_unf;

    int n_vec = 0;
    int n_err = 0;

    jump_ctrl #(
        .D         (D),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_ctr   (prog_ctr),
        .instr_vld  (instr_vld),
        .jop        (jop),
        .jtarget    (jtarget),
        .flag_we    (flag_we),
        .zero_in    (zero_in),
        .carry_in   (carry_in),
        .absjump_en (absjump_en),
        .target     (target),
        .ras_depth  (ras_depth),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_ras[$];
    bit m_z = 0, m_c = 0, m_ovf = 0, m_unf = 0;
    bit started = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_ras.delete();
            m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0;
            started = 1;
        end else begin
            if (instr_vld && jop == 3'd5) begin
                if (m_ras.size() == RAS_DEPTH) m_ovf = 1;
                else m_ras.push_back(8'(prog_ctr[9:2] + 8'd1));
            end else if (instr_vld && jop == 3'd6) begin
                if (m_ras.size() == 0) m_unf = 1;
                else void'(m_ras.pop_back());
            end
            if (flag_we) begin
                m_z = zero_in;
                m_c = carry_in;
            end
        end
    end

    always @(negedge clk) begin
        bit         e_en;
        logic [7:0] e_tgt;
        if (started) begin
            e_en  = 0;
            e_tgt = jtarget;
            if (instr_vld) begin
                case (jop)
                    3'd1: e_en = 1;
                    3'd2: e_en = m_z;
                    3'd3: e_en = !m_z;
                    3'd4: e_en = m_c;
                    3'd5: e_en = 1;
                    3'd6: if (m_ras.size() != 0) begin
                        e_en  = 1;
                        e_tgt = m_ras[m_ras.size()-1];
                    end
                    default: e_en = 0;
                endcase
            end
            n_vec++;
            if (absjump_en !== e_en || target !== e_tgt || ras_depth !== 3'(m_ras.size())
                || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                n_err++;
                $display("FAIL model t=%0t: got en=%b tgt=%h dep=%0d ovf=%b unf=%b, want en=%b tgt=%h dep=%0d ovf=%b unf=%b",
                         $time, absjump_en, target, ras_depth, ras_ovf, ras_unf,
                         e_en, e_tgt, m_ras.size(), m_ovf, m_unf);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set(input logic vld, input logic [2:0] op, input logic [7:0] tgt,
                       input logic [9:0] pc, input logic fwe, input logic z, input logic c);
        instr_vld = vld; jop = op; jtarget = tgt; prog_ctr = pc;
        flag_we = fwe; zero_in = z; carry_in = c;
        #1;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("reset_depth", 8'(ras_depth), 8'd0);
        chk("reset_ovf", 8'(ras_ovf), 8'd0);
        chk("reset_unf", 8'(ras_unf), 8'd0);

        // JMP and invalid
        set(1, 3'd1, 8'h2A, 10'h000, 0, 0, 0);
        chk("jmp_en", 8'(absjump_en), 8'd1);
        chk("jmp_tgt", target, 8'h2A);
        set(0, 3'd1, 8'h2A, 10'h000, 0, 0, 0);
        chk("invalid_en", 8'(absjump_en), 8'd0);
        set(1, 3'd7, 8'h2A, 10'h000, 0, 0, 0);
        chk("reserved_en", 8'(absjump_en), 8'd0);
        tick();

        // Flags: JZ in the write cycle sees the old flag, next cycle sees the new one
        set(1, 3'd2, 8'h10, 10'h000, 1, 1, 0);
        chk("jz_same_cycle", 8'(absjump_en), 8'd0);
        tick();
        set(1, 3'd2, 8'h10, 10'h000, 0, 0, 0);
        chk("jz_taken", 8'(absjump_en), 8'd1);
        chk("jz_tgt", target, 8'h10);
        set(1, 3'd3, 8'h11, 10'h000, 0, 0, 0);
        chk("jnz_not_taken", 8'(absjump_en), 8'd0);
        set(1, 3'd4, 8'h12, 10'h000, 1, 0, 1);
        chk("jc_old_carry", 8'(absjump_en), 8'd0);
        tick();
        set(1, 3'd4, 8'h12, 10'h000, 0, 0, 0);
        chk("jc_taken", 8'(absjump_en), 8'd1);
        tick();

        // CALL/RET round trip
        set(1, 3'd5, 8'h80, 10'h0FF, 0, 0, 0);
        chk("call_en", 8'(absjump_en), 8'd1);
        chk("call_tgt", target, 8'h80);
        tick();
        chk("call_depth", 8'(ras_depth), 8'd1);
        set(1, 3'd6, 8'h55, 10'h200, 0, 0, 0);
        chk("ret_en", 8'(absjump_en), 8'd1);
        chk("ret_tgt", target, 8'h40);
        tick();
        chk("ret_depth", 8'(ras_depth), 8'd0);

        // Nested calls with overflow
        for (int i = 1; i <= 5; i++) begin
            set(1, 3'd5, 8'h90, 10'(i << 2), 0, 0, 0);
            chk("nest_call_en", 8'(absjump_en), 8'd1);
            tick();
        end
        chk("ovf_set", 8'(ras_ovf), 8'd1);
        chk("ovf_depth", 8'(ras_depth), 8'd4);
        for (int k = 0; k < 4; k++) begin
            set(1, 3'd6, 8'h00, 10'h100, 0, 0, 0);
            chk("nest_ret_tgt", target, 8'(5 - k));
            tick();
        end
        chk("nest_empty", 8'(ras_depth), 8'd0);

        // Return address wraps from block 0xFF
        set(1, 3'd5, 8'h77, 10'h3FF, 0, 0, 0);
        tick();
        set(1, 3'd6, 8'h66, 10'h000, 0, 0, 0);
        chk("wrap_en", 8'(absjump_en), 8'd1);
        chk("wrap_tgt", target, 8'h00);
        tick();

        // Underflow
        set(1, 3'd6, 8'h21, 10'h000, 0, 0, 0);
        chk("unf_en", 8'(absjump_en), 8'd0);
        chk("unf_tgt", target, 8'h21);
        tick();
        chk("unf_set", 8'(ras_unf), 8'd1);
        chk("unf_depth", 8'(ras_depth), 8'd0);
        set(1, 3'd0, 8'h00, 10'h000, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("unf_sticky", 8'(ras_unf), 8'd1);
        chk("ovf_sticky", 8'(ras_ovf), 8'd1);

        // Reset mid-operation
        set(1, 3'd0, 8'h00, 10'h000, 1, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set(1, 3'd5, 8'hA0, 10'(i << 3), 0, 0, 0);
            tick();
        end
        chk("pre_rst_depth", 8'(ras_depth), 8'd3);
        set(0, 3'd0, 8'h00, 10'h000, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_depth", 8'(ras_depth), 8'd0);
        chk("rst_ovf", 8'(ras_ovf), 8'd0);
        chk("rst_unf", 8'(ras_unf), 8'd0);
        set(1, 3'd2, 8'h33, 10'h000, 0, 0, 0);
        chk("rst_zero_cleared", 8'(absjump_en), 8'd0);
        set(1, 3'd6, 8'h34, 10'h000, 0, 0, 0);
        chk("rst_ret_en", 8'(absjump_en), 8'd0);
        tick();
        set(0, 3'd0, 8'h00, 10'h000, 0, 0, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Produces `absjump_en` and the 8-bit block `target` consumed by the program counter. The PC loads `target` into `prog_ctr[D-1:2]`, so every jump lands on a 4-instruction-aligned block.
- Decodes the jump opcode of the instruction currently at `prog_ctr`.
- Holds the architectural zero and carry flags.
- Holds a small return-address stack (RAS) for CALL/RET.
- Sits between the instruction decoder/ALU and the PC.

Parameters:
- D, 10, program counter width; block address width is D-2 (8 at default).
- RAS_DEPTH, 4, number of return-address entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- prog_ctr  in  D  current PC value from the PC
- instr_vld  in  1  current instruction is valid; when 0, `jop` is treated as NONE
- jop  in  3  jump opcode: 0 NONE, 1 JMP, 2 JZ, 3 JNZ, 4 JC, 5 CALL, 6 RET, 7 reserved (treated as NONE)
- jtarget  in  D-2  block address from the instruction/LUT
- flag_we  in  1  latch ALU flags this cycle
- zero_in  in  1  ALU zero result
- carry_in  in  1  ALU carry-out
- absjump_en  out  1  to PC; jump taken this cycle
- target  out  D-2  to PC; block address to load
- ras_depth  out  $clog2(RAS_DEPTH)+1  current RAS occupancy
- ras_ovf  out  1  sticky: CALL issued while the RAS was full
- ras_unf  out  1  sticky: RET issued while the RAS was empty

Behaviour:
- Reset (synchronous, priority over everything): zero_f=0, carry_f=0, RAS pointer=0, ras_depth=0, ras_ovf=0, ras_unf=0. RAS contents are don't-care.
- Outputs `absjump_en` and `target` are combinational from jop, jtarget, instr_vld, the registered flags and the RAS top. There is zero added latency; the PC samples them on the same edge.
- Flags:
  - On clk edge with flag_we=1: zero_f<=zero_in, carry_f<=carry_in.
  - Conditional jumps in the same cycle use the old, registered flags. There is no forwarding.
- Decode (effective op = NONE when instr_vld=0):
  - NONE: absjump_en=0. target=jtarget, which is don't-care but driven.
  - JMP: absjump_en=1, target=jtarget.
  - JZ: absjump_en=zero_f, target=jtarget.
  - JNZ: absjump_en=!zero_f, target=jtarget.
  - JC: absjump_en=carry_f, target=jtarget.
  - CALL:
    - absjump_en=1, target=jtarget.
    - On the edge, push ret = prog_ctr[D-1:2]+1, truncated to D-2 bits (wraps 0xFF->0x00 at default).
    - The return lands at the start of the next block. Software places CALL at block offset 3 or pads with NOPs; the hardware does not check this.
  - RET, RAS not empty: absjump_en=1, target=RAS top; pop on the edge.
  - RET, RAS empty: absjump_en=0 (falls through), target=jtarget, no pop; ras_unf<=1.
- RAS full (ras_depth==RAS_DEPTH) on CALL: the jump is still taken, the push is discarded, depth is unchanged, and ras_ovf<=1.
- ras_ovf and ras_unf stay set until reset.
- Only one jop per cycle, so push and pop never coincide.
- flag_we is independent of jop; flag update and jump may occur in the same cycle.
- Reset asserted mid-sequence (e.g. with RAS occupied) empties the RAS. absjump_en is still driven combinationally during reset, but the PC ignores it because its own reset has priority.

Decomposition:
- Shared package `jump_pkg`:
  - enum `jop_t`: JOP_NONE, JOP_JMP, JOP_JZ, JOP_JNZ, JOP_JC, JOP_CALL, JOP_RET.
  - Constant BLK_W = D-2 as a package localparam default of 8.
- The decoder/assembler also imports `jump_pkg`.
- One natural sub-module: `ras_stack`, a LIFO with push, pop, top, depth, full, empty, parameterised by RAS_DEPTH and width.
- Flag register and decode stay in `jump_ctrl`.

Test Plan:
- JMP and invalid: reset, then jop=JMP, jtarget=0x2A -> absjump_en=1, target=0x2A; same with instr_vld=0 -> absjump_en=0.
- Conditional jumps use registered flags: flag_we=1, zero_in=1 in cycle N; JZ 0x10 in cycle N+1 -> taken, target 0x10. JZ issued in cycle N itself, with prior zero_f=0 -> not taken. JNZ after zero_f=1 -> not taken.
- CALL/RET round trip: prog_ctr=0x0FF (block 0x3F), CALL 0x80 -> target 0x80, ras_depth=1. Then RET -> absjump_en=1, target=0x40, ras_depth=0.
- Nested calls, overflow and wrap: 5 CALLs from blocks 0x01..0x05 with RAS_DEPTH=4 -> 5th jump taken, ras_ovf=1, depth=4. Then 4 RETs return 0x05, 0x04, 0x03, 0x02 in order. A CALL from block 0xFF pushes 0x00.
- Underflow: RET with empty RAS -> absjump_en=0, ras_unf=1, depth stays 0; ras_unf persists across 10 NONE cycles.
- Reset mid-operation: depth=3, zero_f=1, assert reset 1 cycle -> depth=0, zero_f=0, stickies 0; next RET -> not taken.
